// File: rtl/demux_1to2_reg.sv
// ----------------------------------------------------------------------------
// demux_1to2_reg
//   Registered 1-to-2 demultiplexer with a valid/ready handshake. It is the
//   inverse of the 2:1 word mux in the multiplier datapath. Each incoming word
//   is steered to one of two consumers, for example the product to the display
//   path or to the accumulator. Each output channel has a one-entry holding
//   register. Per-channel counters record how many words each channel has
//   accepted, for debug.
//
// Parameters
//   WORD_LENGTH  operand width in bits
//   WORD         data path width (product width, WORD_LENGTH*2)
//   CNT_WIDTH    width of the per-channel accepted-word counters
//
// Ports
//   clk          single clock; all state updates on posedge
//   reset        asynchronous, active-low reset
//   in_valid     upstream word valid
//   in_ready     block can accept the word this cycle (combinational)
//   in_sel       route select: 1 -> channel 0, 0 -> channel 1
//   in_data      upstream word
//   out0_valid   channel 0 holds a word
//   out0_ready   channel 0 consumer accepts
//   out0_data    channel 0 word
//   out1_valid   channel 1 holds a word
//   out1_ready   channel 1 consumer accepts
//   out1_data    channel 1 word
//   count0       words accepted into channel 0 since reset (wraps)
//   count1       words accepted into channel 1 since reset (wraps)
// ----------------------------------------------------------------------------
module demux_1to2_reg #(
    parameter int WORD_LENGTH = 4,
    parameter int WORD        = WORD_LENGTH * 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sel,
    input  logic [WORD-1:0]      in_data,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WORD-1:0]      out0_data,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [WORD-1:0]      out1_data,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // A channel can take a word when it is empty or is being drained this
    // cycle. That allows one word per cycle per path. in_ready follows in_sel
    // even when in_valid is low.
    always_comb begin
        in_ready = 1'b0;
        if (in_sel) begin
            in_ready = !out0_valid || out0_ready;
        end else begin
            in_ready = !out1_valid || out1_ready;
        end
    end

    assign load0  = in_valid && in_ready && in_sel;
    assign load1  = in_valid && in_ready && !in_sel;
    assign drain0 = out0_valid && out0_ready;
    assign drain1 = out1_valid && out1_ready;

    // Channel 0 holding register and its valid bit (EMPTY/FULL).
    // A load takes priority over a drain, so a simultaneous load and drain
    // replaces the word and keeps valid set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            count0     <= '0;
        end else if (load0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            count0     <= count0 + CNT_WIDTH'(1);
        end else if (drain0) begin
            out0_valid <= 1'b0;
        end
    end

    // Channel 1 holding register and its valid bit (EMPTY/FULL).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            count1     <= '0;
        end else if (load1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            count1     <= count1 + CNT_WIDTH'(1);
        end else if (drain1) begin
            out1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1to2_reg.sv
module tb_demux_1to2_reg;

    localparam int WORD_LENGTH = 4;
    localparam int WORD        = WORD_LENGTH * 2;
    localparam int CNT_WIDTH   = 8;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sel;
    logic [WORD-1:0]      in_data;
    logic                 out0_valid;
    logic                 out0_ready;
    logic [WORD-1:0]      out0_data;
    logic                 out1_valid;
    logic                 out1_ready;
    logic [WORD-1:0]      out1_data;
    logic [CNT_WIDTH-1:0] count0;
    logic [CNT_WIDTH-1:0] count1;

    demux_1to2_reg #(
        .WORD_LENGTH(WORD_LENGTH),
        .WORD(WORD),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel(in_sel),
        .in_data(in_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data(out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data(out1_data),
        .count0(count0),
        .count1(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic                 m_v0, m_v1;
    logic [WORD-1:0]      m_d0, m_d1;
    logic [CNT_WIDTH-1:0] m_c0, m_c1;
    logic [WORD-1:0]      q0[$];
    logic [WORD-1:0]      q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_d0 = '0;   m_d1 = '0;
        m_c0 = '0;   m_c1 = '0;
        q0.delete(); q1.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out0_valid"}, 32'(out0_valid), 32'(m_v0));
        chk({tag, ".out1_valid"}, 32'(out1_valid), 32'(m_v1));
        chk({tag, ".out0_data"},  32'(out0_data),  32'(m_d0));
        chk({tag, ".out1_data"},  32'(out1_data),  32'(m_d1));
        chk({tag, ".count0"},     32'(count0),     32'(m_c0));
        chk({tag, ".count1"},     32'(count1),     32'(m_c1));
    endtask

    // One clock cycle: drive at negedge, check comb/registered outputs,
    // score drains against the queues, then advance the model at posedge.
    task automatic cyc(input string tag, input logic iv, input logic sel,
                       input logic [WORD-1:0] d, input logic r0, input logic r1);
        logic m_rdy, acc, dr0, dr1;
        logic [WORD-1:0] e;
        in_valid   = iv;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        m_rdy = sel ? (!m_v0 || r0) : (!m_v1 || r1);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
        check_outputs(tag);
        dr0 = m_v0 && r0;
        dr1 = m_v1 && r1;
        acc = iv && m_rdy;
        if (dr0) begin
            e = (q0.size() > 0) ? q0.pop_front() : 'x;
            chk({tag, ".drain0"}, 32'(out0_data), 32'(e));
        end
        if (dr1) begin
            e = (q1.size() > 0) ? q1.pop_front() : 'x;
            chk({tag, ".drain1"}, 32'(out1_data), 32'(e));
        end
        @(posedge clk);
        if (acc && sel) begin
            q0.push_back(d);
            m_v0 = 1'b1; m_d0 = d; m_c0 = m_c0 + 1'b1;
        end else if (dr0) begin
            m_v0 = 1'b0;
        end
        if (acc && !sel) begin
            q1.push_back(d);
            m_v1 = 1'b1; m_d1 = d; m_c1 = m_c1 + 1'b1;
        end else if (dr1) begin
            m_v1 = 1'b0;
        end
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check the clear happens without
    // an edge; release at a negedge and check the first cycle shows no valid.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_outputs({tag, ".post"});
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("rst");
        reset = 1'b1;

        // 1: single word into channel 0
        cyc("t1a", 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0);
        cyc("t1b", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // 2: channel 1 backpressure, then release
        cyc("t2a", 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cyc("t2b", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cyc("t2c", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cyc("t2d", 1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
        cyc("t2e", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // 3: channel 0 held full while channel 1 takes a word
        cyc("t3a", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        cyc("t3b", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        cyc("t3c", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        cyc("t3d", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc("t3e", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        cyc("t3f", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // 4: 256-word stream into channel 0, counter wraps
        do_reset("r4");
        for (int i = 0; i < 256; i++) begin
            cyc("t4", 1'b1, 1'b1, WORD'(i * 7 + 3), 1'b1, 1'b1);
        end
        cyc("t4end", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        chk("t4.count0_wrap", 32'(count0), 32'h0);
        chk("t4.count1",      32'(count1), 32'h0);

        // 5: both channels full, reset mid-stream
        cyc("t5a", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        cyc("t5b", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        cyc("t5c", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset("r5");

        // 6: alternating select, both consumers always ready
        for (int i = 1; i <= 8; i++) begin
            cyc("t6", 1'b1, (i % 2) == 1, WORD'(i), 1'b1, 1'b1);
        end
        cyc("t6end", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t6.count0", 32'(count0), 32'd4);
        chk("t6.count1", 32'(count1), 32'd4);
        chk("t6.q0_empty", 32'(q0.size()), 32'd0);
        chk("t6.q1_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
